pipe_ctrl: RTL

- Central pipeline control unit for the 5-stage core.
- Arbitrates stall requests from ID, EX and MEM into the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Raises the pipeline flush and redirect PC on exceptions and ERET.
- Tracks pipeline state, counts stall/flush events and flags a stuck stall via a watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 40 ++++
 rtl/pipe_ctrl_if.sv | 31 +++
 rtl/pipe_ctrl_cnt.sv | 68 ++++++
 rtl/pipe_ctrl.sv | 79 +++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: stall vectors, exception
// codes, FSM encodings and the redirect-target decode.
package pipe_ctrl_pkg;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_INT          = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
  localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_OV           = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_TIMEOUT = 2'd3
  } ctrl_state_e;

  function automatic logic [31:0] exc_target(
    input logic [31:0] code,
    input logic [31:0] epc,
    input logic [31:0] int_vec,
    input logic [31:0] exc_vec
  );
    logic [31:0] target;
    case (code)
      EXC_INT:  target = int_vec;
      EXC_ERET: target = epc;
      EXC_SYSCALL, EXC_INST_INVALID, EXC_TRAP, EXC_OV: target = exc_vec;
      default:  target = exc_vec;
    endcase
    return target;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/exception inputs and stall/flush/status outputs of pipe_ctrl.
// The master side drives requests; the slave side is the control unit.
interface pipe_ctrl_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic        cnt_clr_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  logic        stall_timeout;

  modport master (
    output stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i, cnt_clr_i,
    input  stall, flush, new_pc, ctrl_state,
    input  stall_cycles, flush_count, stall_timeout
  );

  modport slave (
    input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i, cnt_clr_i,
    output stall, flush, new_pc, ctrl_state,
    output stall_cycles, flush_count, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl_cnt.sv
// Saturating event counters, stall run-length counter and the sticky
// watchdog flag for pipe_ctrl.
module pipe_ctrl_cnt #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_act_i,
  input  logic        flush_i,
  input  logic        cnt_clr_i,
  input  logic        set_timeout_i,
  output logic [15:0] run_len_o,
  output logic [31:0] stall_cycles_o,
  output logic [15:0] flush_count_o,
  output logic        stall_timeout_o
);

  localparam logic [15:0] RUN_SAT = 16'(TIMEOUT);

  logic [15:0] run_len_q, run_len_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    run_len_d = '0;
    if (stall_act_i && !flush_i)
      run_len_d = (run_len_q == RUN_SAT) ? run_len_q : run_len_q + 16'd1;

    stall_cycles_d = stall_cycles_q;
    if (stall_act_i && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 32'd1;

    flush_count_d = flush_count_q;
    if (flush_i && (flush_count_q != '1))
      flush_count_d = flush_count_q + 16'd1;

    timeout_d = timeout_q | set_timeout_i;

    // Clear wins over any same-cycle increment or watchdog set; the
    // run-length counter is deliberately left alone.
    if (cnt_clr_i) begin
      stall_cycles_d = '0;
      flush_count_d  = '0;
      timeout_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_len_q      <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
      timeout_q      <= 1'b0;
    end else begin
      run_len_q      <= run_len_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
      timeout_q      <= timeout_d;
    end
  end

  assign run_len_o       = run_len_q;
  assign stall_cycles_o  = stall_cycles_q;
  assign flush_count_o   = flush_count_q;
  assign stall_timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: stall arbitration, exception flush/redirect,
// state tracking and stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter logic [31:0] EXC_VEC = 32'h0000_0040,
  parameter logic [31:0] INT_VEC = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [15:0] RUN_LAST = 16'(TIMEOUT - 1);

  ctrl_state_e state_q, state_d;
  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] new_pc_c;
  logic [15:0] run_len;
  logic        enter_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = ST_RUN;
    if (flush_c)
      state_d = ST_FLUSH;
    else if ((stall_c != STALL_NONE) && (run_len == RUN_LAST))
      state_d = ST_TIMEOUT;
    else if (stall_c != STALL_NONE)
      state_d = (state_q == ST_TIMEOUT) ? ST_TIMEOUT : ST_STALL;
  end

  // Outputs are combinational so the pipeline registers see them at the
  // coming edge; an exception outranks every stall request.
  always_comb begin
    stall_c  = STALL_NONE;
    flush_c  = 1'b0;
    new_pc_c = '0;
    if (rst) begin
      if (bus.excepttype_i != '0) begin
        flush_c  = 1'b1;
        new_pc_c = exc_target(bus.excepttype_i, bus.cp0_epc_i, INT_VEC, EXC_VEC);
      end else if (bus.stallreq_from_mem) begin
        stall_c = STALL_MEM;
      end else if (bus.stallreq_from_ex) begin
        stall_c = STALL_EX;
      end else if (bus.stallreq_from_id) begin
        stall_c = STALL_ID;
      end
    end
  end

  assign enter_timeout = (state_d == ST_TIMEOUT) && (state_q != ST_TIMEOUT);

  pipe_ctrl_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk            (clk),
    .rst            (rst),
    .stall_act_i    (stall_c != STALL_NONE),
    .flush_i        (flush_c),
    .cnt_clr_i      (bus.cnt_clr_i),
    .set_timeout_i  (enter_timeout),
    .run_len_o      (run_len),
    .stall_cycles_o (bus.stall_cycles),
    .flush_count_o  (bus.flush_count),
    .stall_timeout_o(bus.stall_timeout)
  );

  assign bus.stall      = stall_c;
  assign bus.flush      = flush_c;
  assign bus.new_pc     = new_pc_c;
  assign bus.ctrl_state = state_q;

endmodule
